// File: rtl/mem_vga_access_seq.sv
// Execute-stage access sequencer: turns one decoded LDR/STR/VGP/VGF into a memory
// or VGA handshake, stalls the core until it completes and flags bus errors.
module mem_vga_access_seq #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              read,
  input  logic              write,
  input  logic              flip,
  input  logic              print,
  input  logic [DATA_W-1:0] op_i,
  input  logic [DATA_W-1:0] op_j,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              vga_busy,
  output logic              vga_print,
  output logic              vga_flip,
  output logic [DATA_W-1:0] vga_pos,
  output logic [DATA_W-1:0] vga_data,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_we,
  output logic              stall,
  output logic              bus_err
);

  typedef enum logic [2:0] {
    IDLE,
    MEM_RD,
    MEM_WR,
    VGA_WAIT,
    VGA_CMD,
    DONE
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic              flip_reg;
  logic              rd_ok_reg;
  logic [ADDR_W-1:0] addr_src;
  logic [2:0]        strobe_cnt;
  logic              one_strobe;
  logic              multi_strobe;
  logic              accept;
  logic              lat_rd, lat_wr, lat_vga;
  logic              cap_rd;
  logic              set_err;

  // Address comes from the low bits of Rj, zero-extended when the bus is wider.
  generate
    if (ADDR_W > DATA_W) begin : g_zext
      assign addr_src = {{(ADDR_W - DATA_W){1'b0}}, op_j};
    end else begin : g_trunc
      assign addr_src = op_j[ADDR_W-1:0];
    end
  endgenerate

  assign strobe_cnt   = {2'b00, read} + {2'b00, write} + {2'b00, flip} + {2'b00, print};
  assign one_strobe   = (strobe_cnt == 3'd1);
  assign multi_strobe = (strobe_cnt > 3'd1);
  assign accept       = start && (state_reg == IDLE);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    lat_rd     = 1'b0;
    lat_wr     = 1'b0;
    lat_vga    = 1'b0;
    cap_rd     = 1'b0;
    set_err    = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = 8'd0;
        if (accept) begin
          if (multi_strobe) begin
            set_err = 1'b1;
          end else if (read) begin
            lat_rd     = 1'b1;
            state_next = MEM_RD;
          end else if (write) begin
            lat_wr     = 1'b1;
            state_next = MEM_WR;
          end else if (print || flip) begin
            lat_vga    = 1'b1;
            state_next = VGA_WAIT;
          end
        end
      end
      MEM_RD, MEM_WR: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (mem_ack) begin
          cap_rd     = (state_reg == MEM_RD);
          state_next = DONE;
        end else if (cnt_reg == CNT_LAST) begin
          set_err    = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      VGA_WAIT: begin
        if (!vga_busy) state_next = VGA_CMD;
      end
      VGA_CMD: begin
        state_next = DONE;
      end
      DONE: begin
        cnt_next   = 8'd0;
        state_next = IDLE;
      end
      default: begin
        cnt_next   = 8'd0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
      flip_reg  <= 1'b0;
      rd_ok_reg <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      vga_pos   <= '0;
      vga_data  <= '0;
      ld_data   <= '0;
      bus_err   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      // Requests mirror the next state so they drop on the edge that sees ack/timeout.
      mem_rd    <= (state_next == MEM_RD);
      mem_wr    <= (state_next == MEM_WR);
      if (lat_rd || lat_wr) mem_addr <= addr_src;
      if (lat_wr) mem_wdata <= op_i;
      if (lat_vga) begin
        vga_pos  <= op_j;
        vga_data <= op_i;
        flip_reg <= flip;
      end
      if (cap_rd) begin
        ld_data   <= mem_rdata;
        rd_ok_reg <= 1'b1;
      end else if (state_reg == DONE) begin
        rd_ok_reg <= 1'b0;
      end
      if (set_err) bus_err <= 1'b1;
    end
  end

  assign vga_print = (state_reg == VGA_CMD) && !flip_reg;
  assign vga_flip  = (state_reg == VGA_CMD) && flip_reg;
  assign ld_we     = (state_reg == DONE) && rd_ok_reg;
  assign stall     = (state_reg != IDLE) || (start && one_strobe);

endmodule
